stochastic_bit_encoder: RTL and testbench



---
 rtl/sng_pkg.sv | 19 +
 rtl/sng_comparator.sv | 36 +++
 rtl/stochastic_bit_encoder.sv | 138 +++++++++++++
 tb/tb_stochastic_bit_encoder.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/sng_pkg.sv
// Shared types and constants for the stochastic bit encoder.
// The nibble-rotate helper is only referenced when SNG_PRODUCT_EN is defined.
package sng_pkg;

    localparam int SNG_WIDTH = 8;
    localparam int SNG_LEN_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sng_state_e;

    // Swaps the two halves of a sample so the second comparison sees a decorrelated value.
    function automatic logic [SNG_WIDTH-1:0] nibble_rot(input logic [SNG_WIDTH-1:0] v);
        return {v[SNG_WIDTH/2-1:0], v[SNG_WIDTH-1:SNG_WIDTH/2]};
    endfunction

endpackage

// File: rtl/sng_comparator.sv
// Compares one random sample against a threshold, ANDs with an external gate,
// and registers the resulting bit together with its valid qualifier.
module sng_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [WIDTH-1:0] sample_i,
    input  logic [WIDTH-1:0] thresh_i,
    input  logic             gate_i,
    output logic             hit_o,
    output logic             bit_o,
    output logic             valid_o
);

    logic bit_q;
    logic valid_q;

    assign hit_o = (sample_i < thresh_i) & gate_i;

    // The bit is forced low outside enabled cycles so bit_out never carries stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            bit_q   <= en_i & hit_o;
            valid_q <= en_i;
        end
    end

    assign bit_o   = bit_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/stochastic_bit_encoder.sv
// Stochastic number generator: turns a latched probability into a Bernoulli stream,
// one LFSR sample per bit. Define SNG_PRODUCT_EN to add prob_b and emit p*p_b streams.
module stochastic_bit_encoder
    import sng_pkg::*;
#(
    parameter int WIDTH = SNG_WIDTH,
    parameter int LEN_W = SNG_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] prob,
`ifdef SNG_PRODUCT_EN
    input  logic [WIDTH-1:0] prob_b,
`endif
    input  logic [LEN_W-1:0] stream_len,
    input  logic [WIDTH-1:0] rand_bits,
    output logic             lfsr_en,
    output logic             busy,
    output logic             bit_valid,
    output logic             bit_out,
    output logic [LEN_W-1:0] ones_count,
    output logic             done
);

    sng_state_e       state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] ones_q, ones_d;
    logic [WIDTH-1:0] prob_q, prob_d;
    logic             done_q, done_d;
    logic             sample_hit;
    logic             gate;
    logic             run_active;

    assign run_active = (state_q == RUN);

`ifdef SNG_PRODUCT_EN
    logic [WIDTH-1:0] prob_b_q, prob_b_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            prob_b_q <= '0;
        end else begin
            prob_b_q <= prob_b_d;
        end
    end

    always_comb begin
        prob_b_d = prob_b_q;
        if (state_q == IDLE && start) begin
            prob_b_d = prob_b;
        end
    end

    assign gate = (nibble_rot(rand_bits) < prob_b_q);
`else
    assign gate = 1'b1;
`endif

    sng_comparator #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .clk      (clk),
        .rst      (rst),
        .en_i     (run_active),
        .sample_i (rand_bits),
        .thresh_i (prob_q),
        .gate_i   (gate),
        .hit_o    (sample_hit),
        .bit_o    (bit_out),
        .valid_o  (bit_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            ones_q  <= '0;
            prob_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ones_q  <= ones_d;
            prob_q  <= prob_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ones_d  = ones_q;
        prob_d  = prob_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    prob_d = prob;
                    len_d  = stream_len;
                    ones_d = '0;
                    cnt_d  = '0;
                    // A zero-length request completes without consuming any sample.
                    if (stream_len == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                ones_d = ones_q + LEN_W'(sample_hit);
                cnt_d  = cnt_q + LEN_W'(1);
                if (cnt_q == len_q - LEN_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign lfsr_en    = run_active;
    assign busy       = (state_q != IDLE);
    assign ones_count = ones_q;
    assign done       = done_q;

endmodule

// File: tb/tb_stochastic_bit_encoder.sv
// Directed bench for stochastic_bit_encoder driven by a maximal-length 8-bit LFSR model.
module tb_stochastic_bit_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prob;
`ifdef SNG_PRODUCT_EN
  logic [7:0] prob_b;
`endif
  logic [9:0] stream_len;
  logic [7:0] rand_bits;
  logic       lfsr_en;
  logic       busy;
  logic       bit_valid;
  logic       bit_out;
  logic [9:0] ones_count;
  logic       done;

  logic [7:0] lfsr_q = 8'h01;
  logic       lfsr_reseed;

  int n_checks = 0;
  int n_fail   = 0;
  int nvalid, nones, ndone, nen, first_idx, done_idx;
  logic [9:0] final_ones;
  bit got_done;

  always #5 clk = ~clk;

  // x^8+x^6+x^5+x^4+1: visits every non-zero value once per 255 steps.
  always @(posedge clk) begin
    if (lfsr_reseed) lfsr_q <= 8'h01;
    else if (lfsr_en) lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end
  assign rand_bits = lfsr_q;

  stochastic_bit_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prob       (prob),
`ifdef SNG_PRODUCT_EN
    .prob_b     (prob_b),
`endif
    .stream_len (stream_len),
    .rand_bits  (rand_bits),
    .lfsr_en    (lfsr_en),
    .busy       (busy),
    .bit_valid  (bit_valid),
    .bit_out    (bit_out),
    .ones_count (ones_count),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge while IDLE; returns at the negedge after done, with the DUT back in IDLE.
  task automatic run_stream(input logic [7:0] p, input logic [9:0] len, input bit mid_start);
    start = 1'b1;
    prob = p;
    stream_len = len;
    @(negedge clk);
    start = 1'b0;
    prob = 8'($urandom_range(0, 255));
    stream_len = 10'($urandom_range(0, 1023));
    nvalid = 0; nones = 0; ndone = 0; nen = 0;
    first_idx = -1; done_idx = -1; got_done = 0; final_ones = '0;
    for (int i = 0; i < 1200; i++) begin
      if (bit_valid) begin
        if (first_idx < 0) first_idx = i;
        nvalid++;
        nones += int'(bit_out);
      end
      if (lfsr_en) nen++;
      if (done) begin
        ndone++;
        got_done = 1;
        done_idx = i;
        final_ones = ones_count;
        break;
      end
      if (mid_start && i == 10) begin
        start = 1'b1;
        prob = ~p;
        stream_len = 10'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    @(negedge clk);
    check("done_single_cycle", 32'(done), 32'd0);
    check("idle_after_done", 32'(busy), 32'd0);
  endtask

`ifdef SNG_PRODUCT_EN
  function automatic int prod_model(input logic [7:0] pa, input logic [7:0] pb, input int len);
    logic [7:0] v;
    int cnt;
    v = 8'h01;
    cnt = 0;
    for (int k = 0; k < len; k++) begin
      if ((v < pa) && ({v[3:0], v[7:4]} < pb)) cnt++;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    return cnt;
  endfunction
`endif

  initial begin
    rst = 1'b1;
    lfsr_reseed = 1'b1;
    start = 1'b0;
    prob = 8'd0;
    stream_len = 10'd0;
`ifdef SNG_PRODUCT_EN
    prob_b = 8'd255;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out", 32'(bit_out), 32'd0);
    check("rst_ones", 32'(ones_count), 32'd0);
    check("rst_lfsr_en", 32'(lfsr_en), 32'd0);
    rst = 1'b0;
    lfsr_reseed = 1'b0;
    @(negedge clk);

    // Half probability over a full LFSR period: values 1..127 are below 128.
    run_stream(8'd128, 10'd255, 1'b0);
    check("p128_valid_cnt", 32'(nvalid), 32'd255);
    check("p128_ones", 32'(final_ones), 32'd127);
    check("p128_ones_vs_bits", 32'(nones), 32'd127);
    check("p128_first_valid_idx", 32'(first_idx), 32'd1);
    check("p128_done_with_last", 32'(done_idx), 32'd255);
    check("p128_lfsr_en_cnt", 32'(nen), 32'd255);

    // Back-to-back: start lands in the IDLE cycle right after done.
    run_stream(8'd0, 10'd100, 1'b0);
    check("p0_valid_cnt", 32'(nvalid), 32'd100);
    check("p0_ones", 32'(final_ones), 32'd0);
    check("p0_bits", 32'(nones), 32'd0);
    check("p0_lfsr_en_cnt", 32'(nen), 32'd100);
    check("p0_done_cnt", 32'(ndone), 32'd1);

    // Fresh LFSR, p=255: only the sample 255 fails. A mid-run start with p=0 must be ignored.
    lfsr_reseed = 1'b1;
    @(negedge clk);
    lfsr_reseed = 1'b0;
    run_stream(8'd255, 10'd255, 1'b1);
    check("p255_valid_cnt", 32'(nvalid), 32'd255);
    check("p255_ones", 32'(final_ones), 32'd254);
    check("p255_ones_vs_bits", 32'(nones), 32'd254);

    run_stream(8'd77, 10'd0, 1'b0);
    check("len0_valid_cnt", 32'(nvalid), 32'd0);
    check("len0_ones", 32'(final_ones), 32'd0);
    check("len0_lfsr_en_cnt", 32'(nen), 32'd0);
    check("len0_done_cnt", 32'(ndone), 32'd1);

    // Reset mid-stream.
    start = 1'b1;
    prob = 8'd128;
    stream_len = 10'd200;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrun_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bit_valid", 32'(bit_valid), 32'd0);
    check("midrst_ones", 32'(ones_count), 32'd0);
    check("midrst_lfsr_en", 32'(lfsr_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_stream(8'd0, 10'd5, 1'b0);
    check("post_rst_valid_cnt", 32'(nvalid), 32'd5);
    check("post_rst_ones", 32'(final_ones), 32'd0);

`ifdef SNG_PRODUCT_EN
    prob_b = 8'd0;
    run_stream(8'd255, 10'd50, 1'b0);
    check("prod_pb0_valid_cnt", 32'(nvalid), 32'd50);
    check("prod_pb0_ones", 32'(final_ones), 32'd0);

    for (int r = 0; r < 2; r++) begin
      lfsr_reseed = 1'b1;
      @(negedge clk);
      lfsr_reseed = 1'b0;
      prob_b = 8'd128;
      run_stream(8'd128, 10'd255, 1'b0);
      check("prod_p128_ones", 32'(final_ones), 32'(prod_model(8'd128, 8'd128, 255)));
      check("prod_p128_bits", 32'(nones), 32'(prod_model(8'd128, 8'd128, 255)));
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
